fec_block_ctrl: RTL and testbench

Block sequencer for the convolutional FEC stage of the WiMAX PHY chain: randomizer → FEC → interleaver. Collects 96-bit randomized blocks into a ping-pong bit RAM, then replays each block to the encoder core: 6 tail-biting preload bits first, then 96 encode steps gated by interleaver backpressure. Owns all RAM addressing, bank ownership and block framing, so the encoder core is a pure datapath.

---
 rtl/fec_block_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_fec_block_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fec_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : fec_block_ctrl
// Function : Block sequencer for the convolutional FEC stage. Buffers 96-bit
//            randomized blocks in bit RAM and replays each to the encoder
//            as a tail-biting preload followed by backpressured encode steps.
//            FEC_CTRL_PINGPONG_EN selects two banks (fill and encode
//            overlap). Without it, one bank is used and the two run in turn.
// Revision : 1.0  initial release
// ============================================================================
module fec_block_ctrl #(
  parameter int BLOCK_BITS = 96,
  parameter int PRELOAD    = 6,
  parameter int ADDR_W     = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rand_valid,
  output logic              rand_ready,
  output logic              wr_en,
  output logic              wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              rd_en,
  output logic              rd_bank,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              intl_ready,
  output logic              enc_load,
  output logic              enc_step,
  output logic              enc_sof,
  output logic              enc_eof,
  output logic              busy
);

`ifdef FEC_CTRL_PINGPONG_EN
  localparam bit c_pingpong = 1'b1;
`else
  localparam bit c_pingpong = 1'b0;
`endif

  localparam logic [ADDR_W-1:0] c_last_addr    = ADDR_W'(BLOCK_BITS - 1);
  localparam logic [ADDR_W-1:0] c_preload_addr = ADDR_W'(BLOCK_BITS - PRELOAD);
  localparam logic [ADDR_W-1:0] c_addr_one     = ADDR_W'(1);

  typedef enum logic [1:0] {
    R_IDLE    = 2'd0,
    R_PRELOAD = 2'd1,
    R_ENCODE  = 2'd2,
    R_DONE    = 2'd3
  } rd_state_t;

  rd_state_t         r_state;
  rd_state_t         w_state_nxt;
  logic [1:0]        r_full;
  logic [1:0]        w_full_nxt;
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [ADDR_W-1:0] r_wr_addr;
  logic [ADDR_W-1:0] r_rd_addr;
  logic              r_enc_load;
  logic              r_enc_step;
  logic              r_enc_sof;
  logic              r_enc_eof;
  logic              w_rand_ready;
  logic              w_wr_en;
  logic              w_wr_last;
  logic              w_rd_en;
  logic              w_rd_at_last;
  logic              w_done;

  assign w_rand_ready = !r_full[r_wr_bank];
  assign w_wr_en      = rand_valid & w_rand_ready;
  assign w_wr_last    = w_wr_en && (r_wr_addr == c_last_addr);
  assign w_rd_at_last = (r_rd_addr == c_last_addr);

  // Fill side: sequential write address, bank flips on the last bit of a block
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr <= '0;
      r_wr_bank <= 1'b0;
    end else if (w_wr_en) begin
      if (w_wr_last) begin
        r_wr_addr <= '0;
        r_wr_bank <= c_pingpong ? ~r_wr_bank : 1'b0;
      end else begin
        r_wr_addr <= r_wr_addr + c_addr_one;
      end
    end
  end

  // Set and clear can coincide only on opposite banks, so both are applied
  always_comb begin
    w_full_nxt = r_full;
    if (w_done)
      w_full_nxt[r_rd_bank] = 1'b0;
    if (w_wr_last)
      w_full_nxt[r_wr_bank] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_full <= 2'b00;
    else
      r_full <= w_full_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset)
      r_state <= R_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_rd_en     = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      R_IDLE: begin
        if (r_full[r_rd_bank])
          w_state_nxt = R_PRELOAD;
      end
      R_PRELOAD: begin
        w_rd_en = 1'b1;
        if (w_rd_at_last)
          w_state_nxt = R_ENCODE;
      end
      R_ENCODE: begin
        w_rd_en = intl_ready;
        if (intl_ready && w_rd_at_last)
          w_state_nxt = R_DONE;
      end
      R_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = R_IDLE;
      end
      default: w_state_nxt = R_IDLE;
    endcase
  end

  // Read addressing: preload walks the block tail, encode walks from zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_addr <= '0;
      r_rd_bank <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (r_full[r_rd_bank])
            r_rd_addr <= c_preload_addr;
        end
        R_PRELOAD: begin
          r_rd_addr <= w_rd_at_last ? '0 : r_rd_addr + c_addr_one;
        end
        R_ENCODE: begin
          if (w_rd_en)
            r_rd_addr <= w_rd_at_last ? '0 : r_rd_addr + c_addr_one;
        end
        R_DONE: begin
          r_rd_bank <= c_pingpong ? ~r_rd_bank : 1'b0;
        end
        default: r_rd_addr <= '0;
      endcase
    end
  end

  // Encoder strobes line up with RAM data, one clock after the read
  always_ff @(posedge clk) begin
    if (reset) begin
      r_enc_load <= 1'b0;
      r_enc_step <= 1'b0;
      r_enc_sof  <= 1'b0;
      r_enc_eof  <= 1'b0;
    end else begin
      r_enc_load <= w_rd_en && (r_state == R_PRELOAD);
      r_enc_step <= w_rd_en && (r_state == R_ENCODE);
      r_enc_sof  <= w_rd_en && (r_state == R_ENCODE) && (r_rd_addr == '0);
      r_enc_eof  <= w_rd_en && (r_state == R_ENCODE) && w_rd_at_last;
    end
  end

  assign rand_ready = w_rand_ready;
  assign wr_en      = w_wr_en;
  assign wr_bank    = r_wr_bank;
  assign wr_addr    = r_wr_addr;
  assign rd_en      = w_rd_en;
  assign rd_bank    = r_rd_bank;
  assign rd_addr    = r_rd_addr;
  assign enc_load   = r_enc_load;
  assign enc_step   = r_enc_step;
  assign enc_sof    = r_enc_sof;
  assign enc_eof    = r_enc_eof;
  assign busy       = (r_state != R_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fec_block_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_fec_block_ctrl
// Function : Self-checking bench for fec_block_ctrl (scenario table + directed
//            sequences, scoreboard of expected RAM reads and encoder strobes).
// Revision : 1.0  initial release
// ============================================================================
module tb_fec_block_ctrl;

  localparam int BLOCK_BITS = 96;
  localparam int PRELOAD    = 6;
  localparam int ADDR_W     = 7;
  localparam int GUARD_MAX  = 3000;

`ifdef FEC_CTRL_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              rand_valid = 1'b0;
  logic              intl_ready = 1'b0;
  logic              rand_ready, wr_en, wr_bank, rd_en, rd_bank;
  logic [ADDR_W-1:0] wr_addr, rd_addr;
  logic              enc_load, enc_step, enc_sof, enc_eof, busy;

  fec_block_ctrl #(
    .BLOCK_BITS(BLOCK_BITS),
    .PRELOAD   (PRELOAD),
    .ADDR_W    (ADDR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rand_valid(rand_valid),
    .rand_ready(rand_ready),
    .wr_en     (wr_en),
    .wr_bank   (wr_bank),
    .wr_addr   (wr_addr),
    .rd_en     (rd_en),
    .rd_bank   (rd_bank),
    .rd_addr   (rd_addr),
    .intl_ready(intl_ready),
    .enc_load  (enc_load),
    .enc_step  (enc_step),
    .enc_sof   (enc_sof),
    .enc_eof   (enc_eof),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit load;
    int addr;
    bit bank;
  } ev_t;

  typedef struct {
    bit do_rst;
    int n_bits;
    int vmode;      // 0 continuous, 1 two of every three cycles
    int rmode;      // 0 always ready, 1 toggling, 2 held low for 400 cycles
    int exp_loads;
    int exp_steps;
    bit exp_drop;   // rand_ready seen low while a bit was offered
  } scn_t;

  ev_t  issue_q[$];
  ev_t  pend;
  bit   pend_v;
  bit   prev_mid;
  bit   full_m [2];
  int   wa_m;
  bit   wb_m;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_load, n_step, cyc;
  bit   rr_dropped;
  scn_t tbl [5];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_block(input bit b);
    for (int i = BLOCK_BITS - PRELOAD; i < BLOCK_BITS; i++)
      issue_q.push_back('{load: 1'b1, addr: i, bank: b});
    for (int i = 0; i < BLOCK_BITS; i++)
      issue_q.push_back('{load: 1'b0, addr: i, bank: b});
  endtask

  task automatic check_cycle();
    bit  exp_rr;
    ev_t e;
    exp_rr = !full_m[wb_m];
    chk("rand_ready", int'(rand_ready), int'(exp_rr));
    chk("wr_en", int'(wr_en), int'(rand_valid & exp_rr));
    if (rand_valid && exp_rr) begin
      chk("wr_addr", int'(wr_addr), wa_m);
      chk("wr_bank", int'(wr_bank), int'(wb_m));
      if (wa_m == BLOCK_BITS - 1) begin
        full_m[wb_m] = 1'b1;
        push_block(wb_m);
        wa_m = 0;
        if (PP) wb_m = !wb_m;
      end else begin
        wa_m++;
      end
    end
    // strobes for the read issued last cycle
    if (pend_v) begin
      chk("enc_load", int'(enc_load), int'(pend.load));
      chk("enc_step", int'(enc_step), int'(!pend.load));
      chk("enc_sof", int'(enc_sof), int'(!pend.load && pend.addr == 0));
      chk("enc_eof", int'(enc_eof), int'(!pend.load && pend.addr == BLOCK_BITS - 1));
      if (!pend.load && pend.addr == BLOCK_BITS - 1) begin
        full_m[pend.bank] = 1'b0;
        chk("busy_done", int'(busy), 1);
      end
    end else begin
      chk("enc_idle", int'({enc_load, enc_step, enc_sof, enc_eof}), 0);
    end
    if (enc_load) n_load++;
    if (enc_step) n_step++;
    pend_v = 1'b0;
    if (rd_en) begin
      if (issue_q.size() == 0) begin
        chk("rd_en_unexpected", 1, 0);
      end else begin
        e = issue_q.pop_front();
        chk("rd_addr", int'(rd_addr), e.addr);
        chk("rd_bank", int'(rd_bank), int'(e.bank));
        chk("busy_rd", int'(busy), 1);
        if (!e.load && !intl_ready) chk("read_while_stalled", 1, 0);
        pend   = e;
        pend_v = 1'b1;
        prev_mid = e.load && (e.addr != BLOCK_BITS - 1);
      end
    end else begin
      if (prev_mid) chk("preload_gap", 0, 1);
      prev_mid = 1'b0;
    end
  endtask

  task automatic tick(input logic v, input logic ir);
    @(negedge clk);
    rand_valid = v;
    intl_ready = ir;
    #1;
    cyc++;
    check_cycle();
    if (rand_valid && !rand_ready) rr_dropped = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset      = 1'b1;
    rand_valid = 1'b0;
    intl_ready = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_rand_ready", int'(rand_ready), 1);
    chk("rst_wr_en", int'(wr_en), 0);
    chk("rst_wr_bank", int'(wr_bank), 0);
    chk("rst_wr_addr", int'(wr_addr), 0);
    chk("rst_rd_en", int'(rd_en), 0);
    chk("rst_rd_bank", int'(rd_bank), 0);
    chk("rst_rd_addr", int'(rd_addr), 0);
    chk("rst_enc", int'({enc_load, enc_step, enc_sof, enc_eof}), 0);
    chk("rst_busy", int'(busy), 0);
    reset = 1'b0;
    issue_q.delete();
    pend_v     = 1'b0;
    prev_mid   = 1'b0;
    full_m[0]  = 1'b0;
    full_m[1]  = 1'b0;
    wa_m       = 0;
    wb_m       = 1'b0;
    n_load     = 0;
    n_step     = 0;
    rr_dropped = 1'b0;
  endtask

  task automatic run_scn(input scn_t s, input string tag);
    int   acc;
    int   g;
    logic v;
    logic ir;
    if (s.do_rst) do_reset();
    n_load = 0;
    n_step = 0;
    rr_dropped = 1'b0;
    acc = 0;
    g   = 0;
    while ((acc < s.n_bits || issue_q.size() != 0 || pend_v || busy) && g < GUARD_MAX) begin
      v  = (acc < s.n_bits) && (s.vmode == 0 || (g % 3) != 2);
      ir = (s.rmode == 0) ? 1'b1 : (s.rmode == 1) ? logic'(g % 2) : logic'(g >= 400);
      tick(v, ir);
      if (rand_valid && rand_ready) acc++;
      g++;
    end
    chk({tag, "_timeout"}, int'(g < GUARD_MAX), 1);
    chk({tag, "_loads"}, n_load, s.exp_loads);
    chk({tag, "_steps"}, n_step, s.exp_steps);
    chk({tag, "_drop"}, int'(rr_dropped), int'(s.exp_drop));
    chk({tag, "_idle"}, int'(busy), 0);
  endtask

  initial begin : main
    int   acc;
    int   g;
    int   t_full;
    int   t_load;
    int   rr_low;
    scn_t s;

    tbl[0] = '{do_rst: 1, n_bits:  96, vmode: 0, rmode: 0, exp_loads:  6, exp_steps:  96, exp_drop: 1'b0};
    tbl[1] = '{do_rst: 1, n_bits: 192, vmode: 0, rmode: 0, exp_loads: 12, exp_steps: 192, exp_drop: !PP};
    tbl[2] = '{do_rst: 1, n_bits:  96, vmode: 0, rmode: 1, exp_loads:  6, exp_steps:  96, exp_drop: 1'b0};
    tbl[3] = '{do_rst: 1, n_bits: 288, vmode: 0, rmode: 2, exp_loads: 18, exp_steps: 288, exp_drop: 1'b1};
    tbl[4] = '{do_rst: 1, n_bits: 192, vmode: 1, rmode: 1, exp_loads: 12, exp_steps: 192, exp_drop: !PP};
    cyc = 0;

    for (int i = 0; i < 5; i++) begin
      run_scn(tbl[i], $sformatf("scn%0d", i));
    end

    // Latency from the 96th accepted bit, refill stall and bank hand-over
    do_reset();
    acc = 0; g = 0; t_full = -1; t_load = -1; rr_low = 0;
    while ((acc < BLOCK_BITS || issue_q.size() != 0 || pend_v || busy) && g < GUARD_MAX) begin
      tick(acc < BLOCK_BITS, 1'b1);
      if (rand_valid && rand_ready) begin
        acc++;
        if (acc == BLOCK_BITS) t_full = cyc;
      end
      if (enc_load && t_load < 0) t_load = cyc;
      if (!rand_ready) rr_low++;
      g++;
    end
    chk("lat_timeout", int'(g < GUARD_MAX), 1);
    chk("lat_first_load", t_load - t_full, 3);
    chk("lat_rr_low_cycles", rr_low, PP ? 0 : 104);
    chk("lat_rd_bank", int'(rd_bank), int'(PP));
    chk("lat_wr_bank", int'(wr_bank), int'(PP));

    // Reset at encode step 50, then a clean block from bank 0
    do_reset();
    acc = 0; g = 0;
    while (n_step < 50 && g < GUARD_MAX) begin
      tick(acc < BLOCK_BITS, 1'b1);
      if (rand_valid && rand_ready) acc++;
      g++;
    end
    chk("mid_timeout", int'(g < GUARD_MAX), 1);
    s = '{do_rst: 1, n_bits: 96, vmode: 0, rmode: 0, exp_loads: 6, exp_steps: 96, exp_drop: 1'b0};
    run_scn(s, "post_rst");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
